pipe_ctrl: RTL and testbench
============================

# pipe_ctrl

Central sequencer for the 5-stage rv32i pipeline. It generates per-stage register enables, bubble/flush controls, the PC enable, and the `hold` and `use_rd` qualifiers consumed by decode forwarding. It serialises data-memory stalls, instruction-fetch stalls, load-use bubbles and EX-resolved redirects through one small FSM. It sits beside the stage registers in the CPU top and owns no datapath.

## Interface
- LU_BUBBLES, default 1: bubble cycles inserted per load-use hazard (1..3).
- CNT_W, default 32: width of the perf counters (used only with the macro).

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  reset; asynchronous, active-low
- imem_resp  in  1  fetch data valid this cycle
- dmem_req  in  1  MEM stage holds a valid load/store
- dmem_resp  in  1  data memory completes this cycle
- id_valid  in  1  IF/ID holds a valid instruction
- id_rs1_s, id_rs2_s  in  5  decode source registers
- id_use_rs1, id_use_rs2  in  1  the instruction reads that source
- ex_valid  in  1  ID/EX valid
- ex_is_load  in  1  EX instruction is a load
- ex_rd_s  in  5  EX destination
- ex_redirect  in  1  EX resolved a taken branch/jump
- pc_en  out  1  PC register update
- if_id_en, id_ex_en, ex_mm_en, mm_wb_en  out  1  stage register enables
- if_id_flush  out  1  load invalid into IF/ID
- id_ex_bubble  out  1  load invalid into ID/EX
- hold  out  1  global freeze; decode suppresses forwarding
- use_rd  out  1  EX result forwardable (0 when EX holds a load)

## Operation
- States: RUN, DWAIT, IWAIT, IDROP, BUBBLE.
- Load-use hazard (hz): id_valid & ex_valid & ex_is_load & ex_rd_s!=0 & ((id_use_rs1 & id_rs1_s==ex_rd_s) | (id_use_rs2 & id_rs2_s==ex_rd_s)).
- use_rd = !(ex_valid & ex_is_load), in every state.
- Evaluation priority in each cycle: dmem stall > redirect > fetch stall > hz.
- RUN, dmem_req & !dmem_resp:
  - hold=1, all enables 0, pc_en=0.
  - Next state DWAIT.
- DWAIT:
  - Same outputs as the RUN dmem-stall case until dmem_resp.
  - On the dmem_resp cycle, the RUN rules below apply combinationally, with dmem treated as done.
  - Next state is then RUN, BUBBLE, IWAIT or IDROP per those rules.
- RUN, ex_redirect:
  - pc_en=1, all enables 1, if_id_flush=1, id_ex_bubble=1.
  - Redirect overrides hz.
  - If imem_resp=0 on that cycle (stale fetch outstanding), next state IDROP.
- RUN, !imem_resp (no redirect):
  - pc_en=0, if_id_flush=1, back-end enables 1.
  - Next state IWAIT.
- RUN, hz (fetch ok):
  - pc_en=0, if_id_en=0, id_ex_bubble=1, rest 1.
  - Load counter with LU_BUBBLES-1. If nonzero, next state BUBBLE; else stay in RUN.
- BUBBLE:
  - Same outputs as the RUN hz case.
  - Decrement counter; when it reaches 0, next state RUN.
- IWAIT:
  - Back end runs; if_id_flush=1, pc_en=0.
  - imem_resp → RUN with full advance.
  - ex_redirect without imem_resp → IDROP, with pc_en=1 that cycle.
- IDROP:
  - Stale response is discarded: if_id_flush=1 on its arrival, pc_en=0.
  - Next state IWAIT, which waits for the redirected fetch.
- Reset (rst low, any time, including mid-stall):
  - state=RUN, counter=0.
  - Outputs while low: hold=1, all enables 0, pc_en=0, flush/bubble 0, use_rd=1.

## Timing
- All outputs are combinational from state and inputs. No added latency.
- A hazard observed in cycle N is bubbled in the cycle N edge.
- A dmem stall costs exactly (response cycle − request cycle) frozen cycles.
- Redirect penalty is 2 cycles with an immediate fetch; otherwise fetch latency plus 1.
- A dmem stall coinciding with ex_redirect: the redirect is held frozen and applied on the dmem_resp cycle.
- Deassertion of rst takes effect at the next edge.

## Configuration
- PIPE_CTRL_PERF_EN defined: adds outputs `cnt_dstall`, `cnt_istall`, `cnt_bubble`, `cnt_flush` (CNT_W each).
  - They count cycles spent in DWAIT, cycles in IWAIT/IDROP, bubble cycles, and redirects.
  - Counters saturate at all-ones and reset to 0.
- Undefined: counters and their ports are absent; control behaviour is identical.

## Structure
- rv32i_types gains `pipe_ctrl_state_t` (enum of the five states) and `pipe_ctrl_t`, a packed struct of all enable/flush/bubble/hold outputs.
- One sub-module, `hazard_detect`: combinational hz and use_rd.

## Test plan
- Load x5 followed by `add x6,x5,x1` → one cycle with id_ex_bubble=1, pc_en=0, use_rd=0; with LU_BUBBLES=3 → three cycles.
- dmem_req=1, dmem_resp held low for 4 cycles → hold=1 and all enables 0 for exactly 4 cycles, then RUN.
- ex_redirect=1 with imem_resp=1 → if_id_flush=1, id_ex_bubble=1, pc_en=1 for one cycle; hz suppressed the same cycle.
- ex_redirect while a fetch is outstanding (imem_resp=0) → IDROP; the first late imem_resp is flushed, and only the second response advances IF/ID.
- Drop rst low during DWAIT → immediately hold=1 and enables 0; after release, state is RUN; PERF counters read 0.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// Shared types for the pipeline sequencer: FSM states, the packed control word and its two base values.
package pipe_ctrl_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int BUB_CNT_W  = 2;

  typedef enum logic [2:0] {
    RUN,
    DWAIT,
    IWAIT,
    IDROP,
    BUBBLE
  } pipe_ctrl_state_t;

  typedef struct packed {
    logic pc_en;
    logic if_id_en;
    logic id_ex_en;
    logic ex_mm_en;
    logic mm_wb_en;
    logic if_id_flush;
    logic id_ex_bubble;
    logic hold;
  } pipe_ctrl_t;

  localparam pipe_ctrl_t CTRL_ADVANCE = '{
    pc_en: 1'b1, if_id_en: 1'b1, id_ex_en: 1'b1, ex_mm_en: 1'b1, mm_wb_en: 1'b1,
    if_id_flush: 1'b0, id_ex_bubble: 1'b0, hold: 1'b0
  };

  localparam pipe_ctrl_t CTRL_FREEZE = '{
    pc_en: 1'b0, if_id_en: 1'b0, id_ex_en: 1'b0, ex_mm_en: 1'b0, mm_wb_en: 1'b0,
    if_id_flush: 1'b0, id_ex_bubble: 1'b0, hold: 1'b1
  };

endpackage

// File: rtl/pipe_ctrl_if.sv
// Handshake bundle between the pipeline stage registers (master) and the sequencer (slave).
interface pipe_ctrl_if import pipe_ctrl_pkg::*; ();

  logic                  imem_resp;
  logic                  dmem_req;
  logic                  dmem_resp;
  logic                  id_valid;
  logic [REG_ADDR_W-1:0] id_rs1_s;
  logic [REG_ADDR_W-1:0] id_rs2_s;
  logic                  id_use_rs1;
  logic                  id_use_rs2;
  logic                  ex_valid;
  logic                  ex_is_load;
  logic [REG_ADDR_W-1:0] ex_rd_s;
  logic                  ex_redirect;

  logic pc_en;
  logic if_id_en;
  logic id_ex_en;
  logic ex_mm_en;
  logic mm_wb_en;
  logic if_id_flush;
  logic id_ex_bubble;
  logic hold;
  logic use_rd;

  modport master (
    output imem_resp, dmem_req, dmem_resp, id_valid, id_rs1_s, id_rs2_s,
           id_use_rs1, id_use_rs2, ex_valid, ex_is_load, ex_rd_s, ex_redirect,
    input  pc_en, if_id_en, id_ex_en, ex_mm_en, mm_wb_en, if_id_flush,
           id_ex_bubble, hold, use_rd
  );

  modport slave (
    input  imem_resp, dmem_req, dmem_resp, id_valid, id_rs1_s, id_rs2_s,
           id_use_rs1, id_use_rs2, ex_valid, ex_is_load, ex_rd_s, ex_redirect,
    output pc_en, if_id_en, id_ex_en, ex_mm_en, mm_wb_en, if_id_flush,
           id_ex_bubble, hold, use_rd
  );

endinterface

// File: rtl/pipe_ctrl_hazard_detect.sv
// Combinational load-use hazard detection and the EX forwarding qualifier.
module hazard_detect import pipe_ctrl_pkg::*; (
  input  logic                  id_valid,
  input  logic [REG_ADDR_W-1:0] id_rs1_s,
  input  logic [REG_ADDR_W-1:0] id_rs2_s,
  input  logic                  id_use_rs1,
  input  logic                  id_use_rs2,
  input  logic                  ex_valid,
  input  logic                  ex_is_load,
  input  logic [REG_ADDR_W-1:0] ex_rd_s,
  output logic                  hz,
  output logic                  use_rd
);

  logic ex_load;
  logic rs1_hit;
  logic rs2_hit;

  assign ex_load = ex_valid & ex_is_load;
  assign rs1_hit = id_use_rs1 & (id_rs1_s == ex_rd_s);
  assign rs2_hit = id_use_rs2 & (id_rs2_s == ex_rd_s);

  // x0 is never a real producer, so a load targeting it cannot cause a hazard
  assign hz     = id_valid & ex_load & (ex_rd_s != '0) & (rs1_hit | rs2_hit);
  assign use_rd = ~ex_load;

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline sequencer: stage enables, flush/bubble, PC enable, hold and use_rd.
// Define PIPE_CTRL_PERF_EN to add saturating stall/bubble/redirect counters.
module pipe_ctrl import pipe_ctrl_pkg::*; #(
  parameter int LU_BUBBLES = 1
`ifdef PIPE_CTRL_PERF_EN
  , parameter int CNT_W    = 32
`endif
) (
  input  logic             clk,
  input  logic             rst,
  pipe_ctrl_if.slave       bus
`ifdef PIPE_CTRL_PERF_EN
  , output logic [CNT_W-1:0] cnt_dstall
  , output logic [CNT_W-1:0] cnt_istall
  , output logic [CNT_W-1:0] cnt_bubble
  , output logic [CNT_W-1:0] cnt_flush
`endif
);

  localparam logic [BUB_CNT_W-1:0] BUB_LOAD = BUB_CNT_W'(LU_BUBBLES - 1);

  pipe_ctrl_state_t      state_q, state_d;
  logic [BUB_CNT_W-1:0]  bub_q, bub_d;
  pipe_ctrl_t            ctrl;
  logic                  hz;
  logic                  use_rd_raw;
  logic                  dmem_busy;

  hazard_detect u_hazard_detect (
    .id_valid   (bus.id_valid),
    .id_rs1_s   (bus.id_rs1_s),
    .id_rs2_s   (bus.id_rs2_s),
    .id_use_rs1 (bus.id_use_rs1),
    .id_use_rs2 (bus.id_use_rs2),
    .ex_valid   (bus.ex_valid),
    .ex_is_load (bus.ex_is_load),
    .ex_rd_s    (bus.ex_rd_s),
    .hz         (hz),
    .use_rd     (use_rd_raw)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= RUN;
      bub_q   <= '0;
    end else begin
      state_q <= state_d;
      bub_q   <= bub_d;
    end
  end

  // Once in DWAIT the request is already accepted; only the response ends the stall
  assign dmem_busy = (state_q == DWAIT) ? ~bus.dmem_resp : (bus.dmem_req & ~bus.dmem_resp);

  always_comb begin
    state_d = state_q;
    bub_d   = bub_q;
    ctrl    = CTRL_ADVANCE;
    unique case (state_q)
      RUN, DWAIT: begin
        if (dmem_busy) begin
          ctrl    = CTRL_FREEZE;
          state_d = DWAIT;
        end else if (bus.ex_redirect) begin
          ctrl.if_id_flush  = 1'b1;
          ctrl.id_ex_bubble = 1'b1;
          state_d           = bus.imem_resp ? RUN : IDROP;
        end else if (!bus.imem_resp) begin
          ctrl.pc_en       = 1'b0;
          ctrl.if_id_flush = 1'b1;
          state_d          = IWAIT;
        end else if (hz) begin
          ctrl.pc_en        = 1'b0;
          ctrl.if_id_en     = 1'b0;
          ctrl.id_ex_bubble = 1'b1;
          bub_d             = BUB_LOAD;
          state_d           = (BUB_LOAD != '0) ? BUBBLE : RUN;
        end else begin
          state_d = RUN;
        end
      end
      BUBBLE: begin
        ctrl.pc_en        = 1'b0;
        ctrl.if_id_en     = 1'b0;
        ctrl.id_ex_bubble = 1'b1;
        bub_d             = (bub_q != '0) ? bub_q - 1'b1 : '0;
        if (bub_q <= BUB_CNT_W'(1)) state_d = RUN;
      end
      IWAIT: begin
        if (bus.ex_redirect) begin
          ctrl.if_id_flush  = 1'b1;
          ctrl.id_ex_bubble = 1'b1;
          state_d           = bus.imem_resp ? RUN : IDROP;
        end else if (bus.imem_resp) begin
          state_d = RUN;
        end else begin
          ctrl.pc_en       = 1'b0;
          ctrl.if_id_flush = 1'b1;
        end
      end
      IDROP: begin
        ctrl.pc_en       = 1'b0;
        ctrl.if_id_flush = 1'b1;
        if (bus.imem_resp) state_d = IWAIT;
      end
      default: begin
        state_d = RUN;
        bub_d   = '0;
      end
    endcase
    if (!rst) ctrl = CTRL_FREEZE;
  end

  assign bus.pc_en        = ctrl.pc_en;
  assign bus.if_id_en     = ctrl.if_id_en;
  assign bus.id_ex_en     = ctrl.id_ex_en;
  assign bus.ex_mm_en     = ctrl.ex_mm_en;
  assign bus.mm_wb_en     = ctrl.mm_wb_en;
  assign bus.if_id_flush  = ctrl.if_id_flush;
  assign bus.id_ex_bubble = ctrl.id_ex_bubble;
  assign bus.hold         = ctrl.hold;
  assign bus.use_rd       = rst ? use_rd_raw : 1'b1;

`ifdef PIPE_CTRL_PERF_EN
  logic [CNT_W-1:0] cnt_dstall_q, cnt_dstall_d;
  logic [CNT_W-1:0] cnt_istall_q, cnt_istall_d;
  logic [CNT_W-1:0] cnt_bubble_q, cnt_bubble_d;
  logic [CNT_W-1:0] cnt_flush_q,  cnt_flush_d;

  // A bubble without a flush is load-use; bubble plus flush is an applied redirect
  always_comb begin
    cnt_dstall_d = cnt_dstall_q;
    cnt_istall_d = cnt_istall_q;
    cnt_bubble_d = cnt_bubble_q;
    cnt_flush_d  = cnt_flush_q;
    if (state_q == DWAIT && cnt_dstall_q != '1)
      cnt_dstall_d = cnt_dstall_q + CNT_W'(1);
    if ((state_q == IWAIT || state_q == IDROP) && cnt_istall_q != '1)
      cnt_istall_d = cnt_istall_q + CNT_W'(1);
    if (ctrl.id_ex_bubble && !ctrl.if_id_flush && cnt_bubble_q != '1)
      cnt_bubble_d = cnt_bubble_q + CNT_W'(1);
    if (ctrl.id_ex_bubble && ctrl.if_id_flush && cnt_flush_q != '1)
      cnt_flush_d = cnt_flush_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_dstall_q <= '0;
      cnt_istall_q <= '0;
      cnt_bubble_q <= '0;
      cnt_flush_q  <= '0;
    end else begin
      cnt_dstall_q <= cnt_dstall_d;
      cnt_istall_q <= cnt_istall_d;
      cnt_bubble_q <= cnt_bubble_d;
      cnt_flush_q  <= cnt_flush_d;
    end
  end

  assign cnt_dstall = cnt_dstall_q;
  assign cnt_istall = cnt_istall_q;
  assign cnt_bubble = cnt_bubble_q;
  assign cnt_flush  = cnt_flush_q;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: two instances (LU_BUBBLES=1 and 3) share one stimulus stream.
// Output vector order: {pc_en, if_id_en, id_ex_en, ex_mm_en, mm_wb_en, if_id_flush, id_ex_bubble, hold, use_rd}.
module tb_pipe_ctrl;

  logic clk = 1'b0;
  logic rst;
  logic imem_resp, dmem_req, dmem_resp, id_valid;
  logic [4:0] id_rs1_s, id_rs2_s, ex_rd_s;
  logic id_use_rs1, id_use_rs2, ex_valid, ex_is_load, ex_redirect;

  int checks = 0;
  int errors = 0;

  localparam logic [8:0] E_RESET  = 9'b000000011;
  localparam logic [8:0] E_FRZ    = 9'b000000011;
  localparam logic [8:0] E_RUN    = 9'b111110001;
  localparam logic [8:0] E_RUN_LD = 9'b111110000;
  localparam logic [8:0] E_REDIR  = 9'b111111101;
  localparam logic [8:0] E_IFLUSH = 9'b011111001;
  localparam logic [8:0] E_LU     = 9'b001110100;
  localparam logic [8:0] E_LU_NL  = 9'b001110101;

  always #5 clk = ~clk;

  pipe_ctrl_if bus1 ();
  pipe_ctrl_if bus3 ();

  assign bus1.imem_resp = imem_resp;    assign bus3.imem_resp = imem_resp;
  assign bus1.dmem_req = dmem_req;      assign bus3.dmem_req = dmem_req;
  assign bus1.dmem_resp = dmem_resp;    assign bus3.dmem_resp = dmem_resp;
  assign bus1.id_valid = id_valid;      assign bus3.id_valid = id_valid;
  assign bus1.id_rs1_s = id_rs1_s;      assign bus3.id_rs1_s = id_rs1_s;
  assign bus1.id_rs2_s = id_rs2_s;      assign bus3.id_rs2_s = id_rs2_s;
  assign bus1.id_use_rs1 = id_use_rs1;  assign bus3.id_use_rs1 = id_use_rs1;
  assign bus1.id_use_rs2 = id_use_rs2;  assign bus3.id_use_rs2 = id_use_rs2;
  assign bus1.ex_valid = ex_valid;      assign bus3.ex_valid = ex_valid;
  assign bus1.ex_is_load = ex_is_load;  assign bus3.ex_is_load = ex_is_load;
  assign bus1.ex_rd_s = ex_rd_s;        assign bus3.ex_rd_s = ex_rd_s;
  assign bus1.ex_redirect = ex_redirect; assign bus3.ex_redirect = ex_redirect;

`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] c1_d, c1_i, c1_b, c1_f, c3_d, c3_i, c3_b, c3_f;
`endif

  pipe_ctrl #(.LU_BUBBLES(1)) dut1 (
    .clk (clk),
    .rst (rst),
    .bus (bus1)
`ifdef PIPE_CTRL_PERF_EN
    , .cnt_dstall (c1_d), .cnt_istall (c1_i), .cnt_bubble (c1_b), .cnt_flush (c1_f)
`endif
  );

  pipe_ctrl #(.LU_BUBBLES(3)) dut3 (
    .clk (clk),
    .rst (rst),
    .bus (bus3)
`ifdef PIPE_CTRL_PERF_EN
    , .cnt_dstall (c3_d), .cnt_istall (c3_i), .cnt_bubble (c3_b), .cnt_flush (c3_f)
`endif
  );

  logic [8:0] obs1, obs3;
  assign obs1 = {bus1.pc_en, bus1.if_id_en, bus1.id_ex_en, bus1.ex_mm_en, bus1.mm_wb_en,
                 bus1.if_id_flush, bus1.id_ex_bubble, bus1.hold, bus1.use_rd};
  assign obs3 = {bus3.pc_en, bus3.if_id_en, bus3.id_ex_en, bus3.ex_mm_en, bus3.mm_wb_en,
                 bus3.if_id_flush, bus3.id_ex_bubble, bus3.hold, bus3.use_rd};

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Benign pipeline: fetch returns, no memory op, nothing in EX, no redirect
  task automatic apply_stimulus_idle();
    imem_resp = 1'b1; dmem_req = 1'b0; dmem_resp = 1'b0; ex_redirect = 1'b0;
    id_valid = 1'b0; id_rs1_s = 5'd0; id_rs2_s = 5'd0; id_use_rs1 = 1'b0; id_use_rs2 = 1'b0;
    ex_valid = 1'b0; ex_is_load = 1'b0; ex_rd_s = 5'd0;
  endtask

  // lw x5 in EX, add x6,x5,x1 in ID
  task automatic apply_stimulus_load_use();
    apply_stimulus_idle();
    id_valid = 1'b1; id_rs1_s = 5'd5; id_rs2_s = 5'd1; id_use_rs1 = 1'b1; id_use_rs2 = 1'b1;
    ex_valid = 1'b1; ex_is_load = 1'b1; ex_rd_s = 5'd5;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0;
    apply_stimulus_load_use();
    #3;
    check_output("reset_dut1", {23'd0, obs1}, {23'd0, E_RESET});
    check_output("reset_dut3", {23'd0, obs3}, {23'd0, E_RESET});
`ifdef PIPE_CTRL_PERF_EN
    check_output("perf_reset", {c1_d | c1_i | c1_b | c1_f}, 32'd0);
`endif
    tick(); tick();
    rst = 1'b1;
    apply_stimulus_idle();
    #1 check_output("run_after_reset", {23'd0, obs1}, {23'd0, E_RUN});

    tick();
    apply_stimulus_load_use(); ex_rd_s = 5'd0; id_rs1_s = 5'd0;
    #1 check_output("x0_no_hazard", {23'd0, obs1}, {23'd0, E_RUN_LD});
    tick();
    apply_stimulus_load_use(); id_use_rs1 = 1'b0;
    #1 check_output("use_flag_off", {23'd0, obs1}, {23'd0, E_RUN_LD});
    tick();
    apply_stimulus_load_use(); id_valid = 1'b0;
    #1 check_output("id_invalid", {23'd0, obs1}, {23'd0, E_RUN_LD});

    tick();
    apply_stimulus_load_use();
    #1 check_output("lu_dut1_c1", {23'd0, obs1}, {23'd0, E_LU});
    check_output("lu_dut3_c1", {23'd0, obs3}, {23'd0, E_LU});
    tick();
    ex_valid = 1'b0;
    #1 check_output("lu_dut1_done", {23'd0, obs1}, {23'd0, E_RUN});
    check_output("lu_dut3_c2", {23'd0, obs3}, {23'd0, E_LU_NL});
    tick();
    #1 check_output("lu_dut3_c3", {23'd0, obs3}, {23'd0, E_LU_NL});
    tick();
    #1 check_output("lu_dut3_done", {23'd0, obs3}, {23'd0, E_RUN});

    tick();
    apply_stimulus_load_use(); id_rs1_s = 5'd7; id_rs2_s = 5'd5;
    #1 check_output("lu_rs2", {23'd0, obs1}, {23'd0, E_LU});
    tick();
    apply_stimulus_idle();
    #1 check_output("lu_rs2_after", {23'd0, obs1}, {23'd0, E_RUN});
    tick();

    for (int i = 0; i < 4; i++) begin
      tick();
      apply_stimulus_idle(); dmem_req = 1'b1;
      #1 check_output($sformatf("dstall_c%0d", i), {23'd0, obs1}, {23'd0, E_FRZ});
    end
    tick();
    dmem_resp = 1'b1;
    #1 check_output("dstall_resp", {23'd0, obs1}, {23'd0, E_RUN});
    tick();
    apply_stimulus_idle();
    #1 check_output("dstall_back_run", {23'd0, obs1}, {23'd0, E_RUN});

    tick();
    apply_stimulus_load_use(); ex_redirect = 1'b1;
    #1 check_output("redir_over_hz", {23'd0, obs1}, {23'd0, 9'b111111100});
    check_output("redir_over_hz3", {23'd0, obs3}, {23'd0, 9'b111111100});
    tick();
    apply_stimulus_idle();
    #1 check_output("redir_next_dut3", {23'd0, obs3}, {23'd0, E_RUN});

    tick();
    ex_redirect = 1'b1; imem_resp = 1'b0;
    #1 check_output("redir_stale", {23'd0, obs1}, {23'd0, E_REDIR});
    tick();
    apply_stimulus_idle(); imem_resp = 1'b0;
    #1 check_output("idrop_wait", {23'd0, obs1}, {23'd0, E_IFLUSH});
    tick();
    imem_resp = 1'b1;
    #1 check_output("idrop_stale_flushed", {23'd0, obs1}, {23'd0, E_IFLUSH});
    tick();
    imem_resp = 1'b0;
    #1 check_output("iwait_after_drop", {23'd0, obs1}, {23'd0, E_IFLUSH});
    tick();
    imem_resp = 1'b1;
    #1 check_output("second_resp_adv", {23'd0, obs1}, {23'd0, E_RUN});

    tick();
    imem_resp = 1'b0;
    #1 check_output("fetch_stall", {23'd0, obs1}, {23'd0, E_IFLUSH});
    tick();
    ex_redirect = 1'b1;
    #1 check_output("iwait_redirect", {23'd0, obs1}, {23'd0, E_REDIR});
    tick();
    apply_stimulus_idle();
    #1 check_output("iwait_redir_drop", {23'd0, obs1}, {23'd0, E_IFLUSH});
    tick();
    #1 check_output("iwait_redir_adv", {23'd0, obs1}, {23'd0, E_RUN});

    tick();
    dmem_req = 1'b1; ex_redirect = 1'b1;
    #1 check_output("dstall_redir_c0", {23'd0, obs1}, {23'd0, E_FRZ});
    tick();
    #1 check_output("dstall_redir_c1", {23'd0, obs1}, {23'd0, E_FRZ});
    tick();
    dmem_resp = 1'b1;
    #1 check_output("dstall_redir_apply", {23'd0, obs1}, {23'd0, E_REDIR});
    tick();
    apply_stimulus_idle();
    #1 check_output("dstall_redir_run", {23'd0, obs1}, {23'd0, E_RUN});

    tick();
    apply_stimulus_load_use(); imem_resp = 1'b0;
    #1 check_output("fstall_over_hz", {23'd0, obs1}, {23'd0, 9'b011111000});
    tick();
    apply_stimulus_idle();
    #1 check_output("fstall_hz_resume", {23'd0, obs1}, {23'd0, E_RUN});

    tick();
    dmem_req = 1'b1;
    #1 check_output("pre_reset_dwait", {23'd0, obs1}, {23'd0, E_FRZ});
    tick();
    ex_valid = 1'b1; ex_is_load = 1'b1; ex_rd_s = 5'd3;
    rst = 1'b0;
    #1 check_output("reset_in_dwait", {23'd0, obs1}, {23'd0, E_RESET});
    tick();
    rst = 1'b1;
    apply_stimulus_idle();
    #1 check_output("reset_release_run", {23'd0, obs1}, {23'd0, E_RUN});
`ifdef PIPE_CTRL_PERF_EN
    check_output("perf_after_reset", {c1_d | c1_i | c1_b | c1_f}, 32'd0);
`endif

    tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
